// File: rtl/ultrasonic_echo_emulator.sv
// ultrasonic_echo_emulator
// Emulates an ultrasonic ranging sensor. The trigger input goes through a
// synchronizer and must be held high long enough to count as a real trigger.
// An accepted trigger latches the target distance. After the burst delay, the
// block drives an echo pulse whose width encodes that distance, then waits out
// a hold-off time before it accepts the next trigger.
// Optional feature: define ULTRASONIC_EMU_STATS_EN to build the echo and
// runt statistics counters. Without it, both count outputs are tied to zero.
module ultrasonic_echo_emulator #(
  parameter int unsigned CLOCK_FREQ     = 32'd50_000_000,
  parameter int unsigned MIN_TRIG_US    = 32'd10,
  parameter int unsigned BURST_DELAY_US = 32'd250,
  parameter int unsigned US_PER_CM      = 32'd58,
  parameter int unsigned MAX_DIST_CM    = 32'd400,
  parameter int unsigned NO_ECHO_US     = 32'd38000,
  parameter int unsigned HOLDOFF_US     = 32'd10000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trig_i,
  input  logic [8:0] dist_cm_i,
  output logic       echo_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] echo_cnt_o,
  output logic [7:0] runt_cnt_o
);

  localparam logic [31:0] CYC_US       = CLOCK_FREQ / 32'd1_000_000;
  localparam logic [31:0] MIN_TRIG_CYC = MIN_TRIG_US * CYC_US;
  // The burst phase starts one cycle after the trigger-fall cycle, so one
  // cycle is removed from the load value. The echo then rises exactly the
  // full burst delay after the trigger-fall cycle.
  localparam logic [31:0] BURST_LOAD   = (BURST_DELAY_US * CYC_US) - 32'd1;
  localparam logic [31:0] NO_ECHO_CYC  = NO_ECHO_US * CYC_US;
  localparam logic [31:0] HOLDOFF_CYC  = HOLDOFF_US * CYC_US;
  localparam logic [31:0] CNT_MAX      = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TRIG    = 3'd1,
    ST_BURST   = 3'd2,
    ST_ECHO    = 3'd3,
    ST_HOLDOFF = 3'd4
  } state_t;

  logic        sync1_r;
  logic        trig_s;
  logic        trig_prev_r;
  state_t      state_r, state_nxt_s;
  logic [31:0] trig_cnt_r, trig_cnt_nxt_s;
  logic [31:0] timer_r, timer_nxt_s;
  logic [8:0]  dist_r, dist_nxt_s;
  logic        echo_r, echo_nxt_s;
  logic        busy_r, busy_nxt_s;
  logic        done_r, done_nxt_s;

  // Returns the echo width in cycles. In-range distances give a width
  // proportional to the distance. Zero or out-of-range distances give the
  // no-object width.
  function automatic logic [31:0] echo_width(input logic [8:0] d);
    logic [31:0] d32;
    d32 = {23'd0, d};
    if ((d32 >= 32'd1) && (d32 <= MAX_DIST_CM)) begin
      echo_width = d32 * US_PER_CM * CYC_US;
    end else begin
      echo_width = NO_ECHO_CYC;
    end
  endfunction

  // Two-flop synchronizer for the asynchronous trigger, plus a delayed copy
  // of the synchronized trigger for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r     <= 1'b0;
      trig_s      <= 1'b0;
      trig_prev_r <= 1'b0;
    end else begin
      sync1_r     <= trig_i;
      trig_s      <= sync1_r;
      trig_prev_r <= trig_s;
    end
  end

  // Computes the next state, the next counter values and the next
  // registered outputs.
  always_comb begin
    state_nxt_s    = state_r;
    trig_cnt_nxt_s = trig_cnt_r;
    timer_nxt_s    = timer_r;
    dist_nxt_s     = dist_r;
    echo_nxt_s     = 1'b0;
    done_nxt_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // A trigger that is already high on entry shows no edge here, so
        // it is ignored until it drops.
        if (trig_s && !trig_prev_r) begin
          state_nxt_s    = ST_TRIG;
          trig_cnt_nxt_s = 32'd1;
        end else begin
          trig_cnt_nxt_s = 32'd0;
        end
      end
      ST_TRIG: begin
        if (trig_s) begin
          if (trig_cnt_r != CNT_MAX) begin
            trig_cnt_nxt_s = trig_cnt_r + 32'd1;
          end else begin
            trig_cnt_nxt_s = trig_cnt_r;
          end
        end else if (trig_cnt_r >= MIN_TRIG_CYC) begin
          state_nxt_s = ST_BURST;
          dist_nxt_s  = dist_cm_i;
          timer_nxt_s = BURST_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (timer_r <= 32'd1) begin
          state_nxt_s = ST_ECHO;
          echo_nxt_s  = 1'b1;
          timer_nxt_s = echo_width(dist_r);
        end else begin
          timer_nxt_s = timer_r - 32'd1;
        end
      end
      ST_ECHO: begin
        if (timer_r <= 32'd1) begin
          state_nxt_s = ST_HOLDOFF;
          done_nxt_s  = 1'b1;
          timer_nxt_s = HOLDOFF_CYC;
        end else begin
          echo_nxt_s  = 1'b1;
          timer_nxt_s = timer_r - 32'd1;
        end
      end
      ST_HOLDOFF: begin
        if (timer_r <= 32'd1) begin
          state_nxt_s = ST_IDLE;
          timer_nxt_s = 32'd0;
        end else begin
          timer_nxt_s = timer_r - 32'd1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        timer_nxt_s = 32'd0;
      end
    endcase
    busy_nxt_s = (state_nxt_s == ST_BURST) || (state_nxt_s == ST_ECHO) ||
                 (state_nxt_s == ST_HOLDOFF);
  end

  // State, counters and registered outputs. Reset clears everything on the
  // next edge, so an echo in progress ends without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      trig_cnt_r <= 32'd0;
      timer_r    <= 32'd0;
      dist_r     <= 9'd0;
      echo_r     <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      trig_cnt_r <= trig_cnt_nxt_s;
      timer_r    <= timer_nxt_s;
      dist_r     <= dist_nxt_s;
      echo_r     <= echo_nxt_s;
      busy_r     <= busy_nxt_s;
      done_r     <= done_nxt_s;
    end
  end

  assign echo_o = echo_r;
  assign busy_o = busy_r;
  assign done_o = done_r;

`ifdef ULTRASONIC_EMU_STATS_EN
  logic       echo_evt_s;
  logic       runt_evt_s;
  logic [7:0] echo_cnt_r;
  logic [7:0] runt_cnt_r;

  assign echo_evt_s = (state_r == ST_ECHO) && (state_nxt_s == ST_HOLDOFF);
  assign runt_evt_s = (state_r == ST_TRIG) && (state_nxt_s == ST_IDLE);

  // Wrapping statistics counters. The echo count updates on the same edge
  // that raises done.
  always_ff @(posedge clk) begin
    if (rst) begin
      echo_cnt_r <= 8'd0;
      runt_cnt_r <= 8'd0;
    end else begin
      if (echo_evt_s) begin
        echo_cnt_r <= echo_cnt_r + 8'd1;
      end
      if (runt_evt_s) begin
        runt_cnt_r <= runt_cnt_r + 8'd1;
      end
    end
  end

  assign echo_cnt_o = echo_cnt_r;
  assign runt_cnt_o = runt_cnt_r;
`else
  assign echo_cnt_o = 8'd0;
  assign runt_cnt_o = 8'd0;
`endif

endmodule

// File: tb/tb_ultrasonic_echo_emulator.sv
// Directed testbench for ultrasonic_echo_emulator at 1 cycle = 1 us.
// Timing note: trig_i is driven on a falling edge. The cycle in which the
// trigger-fall is seen (cycle F) is the second falling edge after trig_i is
// driven low. The echo therefore rises 250 + 2 = 252 falling edges after
// that drive.
module tb_ultrasonic_echo_emulator;

  localparam int RISE_EXP     = 252;
  localparam int W_10CM       = 580;
  localparam int W_1CM        = 58;
  localparam int W_NO_ECHO    = 38000;
  localparam int HOLDOFF_EXP  = 10000;

  logic       clk = 1'b0;
  logic       rst;
  logic       trig_i;
  logic [8:0] dist_cm_i;
  logic       echo_o;
  logic       busy_o;
  logic       done_o;
  logic [7:0] echo_cnt_o;
  logic [7:0] runt_cnt_o;

  int tests_run    = 0;
  int tests_failed = 0;
  int exp_echo_cnt = 0;
  int exp_runt_cnt = 0;

  ultrasonic_echo_emulator #(
    .CLOCK_FREQ(32'd1_000_000)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .trig_i     (trig_i),
    .dist_cm_i  (dist_cm_i),
    .echo_o     (echo_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .echo_cnt_o (echo_cnt_o),
    .runt_cnt_o (runt_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Holds trig_i high for n cycles and returns on the edge where it is driven low.
  task automatic pulse_trig(input int n);
    trig_i = 1'b1;
    repeat (n) @(negedge clk);
    trig_i = 1'b0;
  endtask

  task automatic wait_rise(output int cnt, input int limit);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!echo_o && cnt < limit);
  endtask

  // Counts echo-high cycles. Optionally injects a 12-cycle trigger that
  // starts at cycle inj_at. Returns on the first edge where echo is low.
  task automatic measure_width(output int w, output int early_done,
                               input int limit, input int inj_at);
    w = 0;
    early_done = 0;
    while (echo_o && w < limit) begin
      if (done_o) early_done++;
      w++;
      if (w == inj_at) trig_i = 1'b1;
      if (w == inj_at + 12) trig_i = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    exp_echo_cnt = 0;
    exp_runt_cnt = 0;
    tick(1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    trig_i = 1'b0;
    dist_cm_i = 9'd0;
    tick(3);
    tests_run++;
    if ({echo_o, busy_o, done_o} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b expected 000", {echo_o, busy_o, done_o});
    end
    tests_run++;
    if (echo_cnt_o !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_echo_cnt: got %0d expected 0", echo_cnt_o);
    end
    tests_run++;
    if (runt_cnt_o !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_runt_cnt: got %0d expected 0", runt_cnt_o);
    end
    rst = 1'b0;
    tick(2);
  endtask

  // A 5-cycle trigger and a 9-cycle trigger (one below the minimum) are both runts.
  task automatic test_runt();
    int widths[2] = '{5, 9};
    int echo_hi, busy_hi;
    foreach (widths[k]) begin
      dist_cm_i = 9'd10;
      pulse_trig(widths[k]);
`ifdef ULTRASONIC_EMU_STATS_EN
      exp_runt_cnt++;
`endif
      echo_hi = 0;
      busy_hi = 0;
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        if (echo_o) echo_hi++;
        if (busy_o) busy_hi++;
      end
      tests_run++;
      if (echo_hi != 0) begin
        tests_failed++;
        $display("FAIL runt_echo: width %0d got %0d echo-high cycles expected 0", widths[k], echo_hi);
      end
      tests_run++;
      if (busy_hi != 0) begin
        tests_failed++;
        $display("FAIL runt_busy: width %0d got %0d busy cycles expected 0", widths[k], busy_hi);
      end
      tests_run++;
      if (runt_cnt_o !== 8'(exp_runt_cnt)) begin
        tests_failed++;
        $display("FAIL runt_cnt: got %0d expected %0d", runt_cnt_o, exp_runt_cnt);
      end
    end
  endtask

  task automatic test_mid_reset();
    int r;
    int busy_hi;
    dist_cm_i = 9'd10;
    pulse_trig(12);
    wait_rise(r, 400);
    tick(100);
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({echo_o, done_o, busy_o} !== 3'b000) begin
      tests_failed++;
      $display("FAIL midreset_outputs: got %b expected 000", {echo_o, done_o, busy_o});
    end
    tests_run++;
    if ({echo_cnt_o, runt_cnt_o} !== 16'd0) begin
      tests_failed++;
      $display("FAIL midreset_counters: got %h expected 0000", {echo_cnt_o, runt_cnt_o});
    end
    rst = 1'b0;
    exp_echo_cnt = 0;
    exp_runt_cnt = 0;
    busy_hi = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (busy_o || echo_o || done_o) busy_hi++;
    end
    tests_run++;
    if (busy_hi != 0) begin
      tests_failed++;
      $display("FAIL midreset_idle: got %0d active cycles expected 0", busy_hi);
    end
  endtask

  // Tests a normal echo, ignored triggers in ECHO and HOLDOFF, a trigger
  // already high at HOLDOFF end, and a minimum-width trigger at 1 cm.
  task automatic test_echo_holdoff();
    int r, w, ed, h, act;
    dist_cm_i = 9'd10;
    pulse_trig(12);
    wait_rise(r, 400);
    tests_run++;
    if (r != RISE_EXP) begin
      tests_failed++;
      $display("FAIL basic_rise: got %0d expected %0d", r, RISE_EXP);
    end
    measure_width(w, ed, 1000, 100);
    tests_run++;
    if (w != W_10CM) begin
      tests_failed++;
      $display("FAIL basic_width: got %0d expected %0d", w, W_10CM);
    end
    tests_run++;
    if (ed != 0) begin
      tests_failed++;
      $display("FAIL basic_early_done: got %0d expected 0", ed);
    end
    tests_run++;
    if (done_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_done: got %b expected 1", done_o);
    end
`ifdef ULTRASONIC_EMU_STATS_EN
    exp_echo_cnt++;
`endif
    tests_run++;
    if (echo_cnt_o !== 8'(exp_echo_cnt)) begin
      tests_failed++;
      $display("FAIL basic_echo_cnt: got %0d expected %0d", echo_cnt_o, exp_echo_cnt);
    end
    h = 0;
    while (busy_o && h < HOLDOFF_EXP + 100) begin
      h++;
      if (h == 2) begin
        tests_run++;
        if (done_o !== 1'b0) begin
          tests_failed++;
          $display("FAIL basic_done_once: got %b expected 0", done_o);
        end
      end
      if (h == 5000) trig_i = 1'b1;
      if (h == 5012) trig_i = 1'b0;
      if (h == 9990) trig_i = 1'b1;
      @(negedge clk);
    end
    tests_run++;
    if (h != HOLDOFF_EXP) begin
      tests_failed++;
      $display("FAIL holdoff_len: got %0d expected %0d", h, HOLDOFF_EXP);
    end
    act = 0;
    for (int i = 0; i < 350; i++) begin
      if (i == 50) trig_i = 1'b0;
      @(negedge clk);
      if (busy_o || echo_o) act++;
    end
    tests_run++;
    if (act != 0) begin
      tests_failed++;
      $display("FAIL held_trig_ignored: got %0d active cycles expected 0", act);
    end
    dist_cm_i = 9'd1;
    pulse_trig(10);
    wait_rise(r, 400);
    tests_run++;
    if (r != RISE_EXP) begin
      tests_failed++;
      $display("FAIL min_trig_rise: got %0d expected %0d", r, RISE_EXP);
    end
    measure_width(w, ed, 1000, -100);
    tests_run++;
    if (w != W_1CM) begin
      tests_failed++;
      $display("FAIL width_1cm: got %0d expected %0d", w, W_1CM);
    end
`ifdef ULTRASONIC_EMU_STATS_EN
    exp_echo_cnt++;
`endif
    tests_run++;
    if (echo_cnt_o !== 8'(exp_echo_cnt)) begin
      tests_failed++;
      $display("FAIL second_echo_cnt: got %0d expected %0d", echo_cnt_o, exp_echo_cnt);
    end
    do_reset();
  endtask

  // The distance changes from 10 to 200 during BURST. The latched 10 cm must be used.
  task automatic test_latch();
    int r, w, ed;
    dist_cm_i = 9'd10;
    pulse_trig(12);
    tick(20);
    dist_cm_i = 9'd200;
    wait_rise(r, 400);
    tests_run++;
    if (r + 20 != RISE_EXP) begin
      tests_failed++;
      $display("FAIL latch_rise: got %0d expected %0d", r + 20, RISE_EXP);
    end
    measure_width(w, ed, 1000, -100);
    tests_run++;
    if (w != W_10CM) begin
      tests_failed++;
      $display("FAIL latch_width: got %0d expected %0d", w, W_10CM);
    end
    do_reset();
  endtask

  task automatic test_no_object(input logic [8:0] d);
    int r, w, ed;
    dist_cm_i = d;
    pulse_trig(12);
    wait_rise(r, 400);
    tests_run++;
    if (r != RISE_EXP) begin
      tests_failed++;
      $display("FAIL noobj_rise: dist %0d got %0d expected %0d", d, r, RISE_EXP);
    end
    measure_width(w, ed, W_NO_ECHO + 100, -100);
    tests_run++;
    if (w != W_NO_ECHO) begin
      tests_failed++;
      $display("FAIL noobj_width: dist %0d got %0d expected %0d", d, w, W_NO_ECHO);
    end
    tests_run++;
    if (done_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL noobj_done: dist %0d got %b expected 1", d, done_o);
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_runt();
    test_mid_reset();
    test_echo_holdoff();
    test_latch();
    test_no_object(9'd0);
    test_no_object(9'd401);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ultrasonic_echo_emulator.md
ULTRASONIC_ECHO_EMULATOR -- requirements
Module: ultrasonic_echo_emulator

Interface
REQ-001 Parameter CLOCK_FREQ, default 50_000_000, system clock frequency in Hz; CYC_US = CLOCK_FREQ/1_000_000.
REQ-002 Parameter MIN_TRIG_US, default 10, minimum accepted trigger high width in us.
REQ-003 Parameter BURST_DELAY_US, default 250, delay from trigger fall to echo rise in us.
REQ-004 Parameter US_PER_CM, default 58, echo width per cm of distance in us.
REQ-005 Parameter MAX_DIST_CM, default 400, largest distance answered with a proportional echo.
REQ-006 Parameter NO_ECHO_US, default 38000, echo width for no-object or out-of-range in us.
REQ-007 Parameter HOLDOFF_US, default 10000, dead time after echo fall in us.
REQ-008 clk  input  1  system clock; all logic on rising edge.
REQ-009 rst  input  1  synchronous, active-high reset.
REQ-010 trig_i  input  1  asynchronous trigger from the sensor controller.
REQ-011 dist_cm_i  input  9  emulated target distance in cm; 0 means no object.
REQ-012 echo_o  output  1  emulated echo pulse, registered.
REQ-013 busy_o  output  1  high in every state except IDLE and TRIG.
REQ-014 done_o  output  1  one-cycle pulse on the cycle echo_o falls.
REQ-015 echo_cnt_o  output  8  generated-echo count (see Configuration).
REQ-016 runt_cnt_o  output  8  rejected-trigger count (see Configuration).

Function
REQ-017 trig_i SHALL pass a 2-flop synchronizer; trig_s denotes the second flop; all trigger timing refers to trig_s.
REQ-018 States SHALL be IDLE, TRIG, BURST, ECHO, HOLDOFF.
REQ-019 IDLE -> TRIG on trig_s rising edge (trig_s=1 while the previous sample was 0); a trig_s already high on IDLE entry SHALL be ignored until it goes low.
REQ-020 TRIG SHALL count cycles with trig_s=1; the counter saturates and never wraps.
REQ-021 In TRIG, on the first cycle F with trig_s=0: if count >= MIN_TRIG_US*CYC_US -> BURST, else -> IDLE and the trigger is a runt.
REQ-022 On cycle F of an accepted trigger, dist_cm_i SHALL be latched; later changes do not affect the measurement.
REQ-023 Echo width W SHALL be latched_dist*US_PER_CM*CYC_US cycles if 1 <= latched_dist <= MAX_DIST_CM, else NO_ECHO_US*CYC_US cycles; arithmetic uses 32-bit unsigned.
REQ-024 echo_o SHALL rise exactly BURST_DELAY_US*CYC_US cycles after F and stay high exactly W cycles (ECHO state).
REQ-025 done_o SHALL pulse for one cycle on the first cycle echo_o is 0 after ECHO; the state then goes to HOLDOFF.
REQ-026 HOLDOFF SHALL last HOLDOFF_US*CYC_US cycles, then -> IDLE; triggers in BURST, ECHO and HOLDOFF are ignored and not counted.

Reset
REQ-027 While rst=1: state=IDLE, all counters 0, synchronizer flops 0, echo_o=0, busy_o=0, done_o=0, echo_cnt_o=0, runt_cnt_o=0.
REQ-028 rst asserted mid-echo SHALL drive echo_o low on the next clock edge with no done_o pulse.

Configuration
REQ-029 With macro ULTRASONIC_EMU_STATS_EN defined: echo_cnt_o increments on each done_o and runt_cnt_o increments on each runt; both wrap 255 -> 0.
REQ-030 Without ULTRASONIC_EMU_STATS_EN: echo_cnt_o and runt_cnt_o SHALL be constant 0 and the counters SHALL NOT be synthesized; all other behaviour is identical.

Verification (CLOCK_FREQ=1_000_000, so 1 cycle = 1 us; other parameters at default)
REQ-031 trig_i high 12 cycles, dist_cm_i=10 -> echo_o rises 250 cycles after F, stays high 580 cycles, then done_o pulses once.
REQ-032 trig_i high 5 cycles -> echo_o stays 0 and busy_o stays 0; runt_cnt_o=1 with the macro, 0 without.
REQ-033 dist_cm_i=0, then dist_cm_i=401 -> echo_o high 38000 cycles in each case.
REQ-034 dist_cm_i changed from 10 to 200 during BURST -> echo width 580 cycles.
REQ-035 Second 12-cycle trigger during ECHO and again during HOLDOFF -> ignored; next echo only after HOLDOFF plus a new rising edge; echo_cnt_o increments by 1 per completed echo.
REQ-036 rst pulsed 100 cycles into ECHO -> echo_o=0 next cycle, no done_o, state IDLE, counters 0.
